// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared state encoding and width helper for the serial
//               pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  // Bits needed to count 0..pat_w valid history bits.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Width-parametrised saturating up-counter with synchronous
//               clear. Holds at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] count_q;

  // Count register: reset beats clear beats increment; stop at the maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != C_MAX)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_fsm.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_fsm
// Description : Serial pattern detector. Shifts qualified bits into a
//               PAT_W-bit history and pulses match when the last PAT_W bits
//               equal the pattern latched at stream start or soft clear.
//               Supports overlapping and flushing (non-overlap) detection.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_fsm
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int FILL_W = fill_width(PAT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_in,
  input  logic              x_valid,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  input  logic              clear,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic [FILL_W-1:0] fill,
  output logic [1:0]        state
);

  localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_W);

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;

  logic [PAT_W-1:0]  ref_pat;
  logic [PAT_W-1:0]  shifted;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;
  logic              cnt_inc;

  // State, history, latched pattern, fill count and registered match pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      pat_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  // Next-state logic: leaving IDLE latches a fresh pattern and starts from an
  // empty history, so the IDLE edge uses the live pattern input for compare.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    pat_d    = pat_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    cnt_inc  = 1'b0;

    ref_pat  = (state_q == ST_IDLE) ? pattern : pat_q;
    shifted  = (state_q == ST_IDLE) ? {{(PAT_W-1){1'b0}}, x_in}
                                    : {hist_q[PAT_W-2:0], x_in};
    fill_inc = (state_q == ST_IDLE) ? FILL_W'(1)
             : ((fill_q == C_FULL) ? C_FULL : fill_q + FILL_W'(1));
    hit      = (fill_inc == C_FULL) && (shifted == ref_pat);

    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      pat_d   = pattern;
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_IDLE, ST_FILL, ST_ARMED: begin
          if (x_valid) begin
            pat_d   = ref_pat;
            hist_d  = shifted;
            fill_d  = fill_inc;
            state_d = (fill_inc == C_FULL) ? ST_ARMED : ST_FILL;
            if (hit) begin
              match_d = 1'b1;
              cnt_inc = 1'b1;
              // Flushing mode: the matching bit is not reused.
              if (!overlap) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = ST_FILL;
              end
            end
          end
        end
        default: begin
          // Illegal encoding: recover to IDLE with an empty history.
          state_d = ST_IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clear),
    .inc_i   (cnt_inc),
    .count_o (match_count)
  );

  assign match = match_q;
  assign fill  = fill_q;
  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_fsm
// Description : Self-checking bench for seq_detector_fsm. Two instances share
//               stimulus (CNT_W=8 and CNT_W=2) and are compared each cycle
//               against a bit-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x_in = 1'b0;
  logic       x_valid = 1'b0;
  logic [3:0] pattern = 4'b1011;
  logic       overlap = 1'b1;
  logic       clear = 1'b0;

  logic       match_a, match_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [2:0] fill_a, fill_b;
  logic [1:0] state_a, state_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit       m_idle;
  int       m_len;
  bit [3:0] m_last;
  bit [3:0] m_pat;
  bit       m_match;
  int       m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detector_fsm #(.PAT_W(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
    .pattern(pattern), .overlap(overlap), .clear(clear),
    .match(match_a), .match_count(count_a), .fill(fill_a), .state(state_a)
  );

  seq_detector_fsm #(.PAT_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
    .pattern(pattern), .overlap(overlap), .clear(clear),
    .match(match_b), .match_count(count_b), .fill(fill_b), .state(state_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: the stream since the last reset/clear/flush is a bit list; a match
  // is "at least four bits seen and the last four equal the latched pattern".
  task automatic model_edge();
    if (reset) begin
      m_idle = 1; m_len = 0; m_last = 0; m_pat = 0; m_match = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (clear) begin
      m_idle = 0; m_len = 0; m_last = 0; m_pat = pattern; m_match = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (x_valid) begin
      if (m_idle) begin
        m_pat  = pattern;
        m_idle = 0;
      end
      m_last  = {m_last[2:0], x_in};
      m_len   = m_len + 1;
      m_match = (m_len >= 4) && (m_last == m_pat);
      if (m_match) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        if (!overlap) begin
          m_len  = 0;
          m_last = 0;
        end
      end
    end else begin
      m_match = 0;
    end
  endtask

  task automatic compare_all();
    int exp_fill;
    int exp_state;
    exp_fill  = (m_len > 4) ? 4 : m_len;
    exp_state = m_idle ? 0 : ((exp_fill == 4) ? 2 : 1);
    check("match_a", int'(match_a), int'(m_match));
    check("match_b", int'(match_b), int'(m_match));
    check("fill_a",  int'(fill_a),  exp_fill);
    check("fill_b",  int'(fill_b),  exp_fill);
    check("state_a", int'(state_a), exp_state);
    check("state_b", int'(state_b), exp_state);
    check("count_a", int'(count_a), m_cnt8);
    check("count_b", int'(count_b), m_cnt2);
  endtask

  task automatic step(input bit rst_v, input bit clr_v, input bit v, input bit b);
    @(negedge clk);
    reset   = rst_v;
    clear   = clr_v;
    x_valid = v;
    x_in    = b;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic bits7(input bit [6:0] s, input bit gaps);
    for (int i = 6; i >= 0; i--) begin
      step(0, 0, 1, s[i]);
      if (gaps) begin
        step(0, 0, 0, 1'b1);
        step(0, 0, 0, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset for two cycles, then idle
    pattern = 4'b1011;
    overlap = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // Overlapping detection: matches after bits 4 and 7
    bits7(7'b1011011, 0);
    step(0, 0, 0, 0);
    check("overlap_count", int'(count_a), 2);

    // Non-overlapping: single match, then three bits remain
    step(1, 0, 0, 0);
    overlap = 1'b0;
    bits7(7'b1011011, 0);
    step(0, 0, 0, 0);
    check("nonovl_count", int'(count_a), 1);
    check("nonovl_fill", int'(fill_a), 3);

    // Gapped valid
    step(1, 0, 0, 0);
    overlap = 1'b1;
    bits7(7'b1011011, 1);
    check("gapped_count", int'(count_a), 2);

    // Clear together with the 4th valid bit
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    check("clear_count", int'(count_a), 0);

    // Saturation on the 2-bit counter: ten ones, matches on bits 4..10
    step(1, 0, 0, 0);
    pattern = 4'b1111;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    check("sat_count_b", int'(count_b), 3);
    check("sat_count_a", int'(count_a), 7);

    // Pattern changed mid-stream is ignored until next IDLE exit
    step(1, 0, 0, 0);
    pattern = 4'b1011;
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    pattern = 4'b0000;
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    check("latched_pat_match", int'(match_a), 1);

    // Reset after bit 3: no match follows
    step(1, 0, 0, 0);
    pattern = 4'b1011;
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    check("reset_mid_nomatch", int'(match_a), 0);

    // Randomized stream
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) pattern = 4'($urandom);
      overlap = 1'($urandom);
      step($urandom_range(0, 90) == 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
